// File: rtl/mips_lsu_pkg.sv
// Shared LSU types and lane-steering helpers.
// Optional feature macro: MIPS_LSU_ALIGN_CHK_EN (adds StErr and the misalignment check).
package mips_lsu_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        MEM_NONE = 2'd0,
        MEM_LD   = 2'd1,
        MEM_ST   = 2'd2
    } mem_op_e;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } mem_sz_e;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StReq  = 3'd1,
        StRsp  = 3'd2,
`ifdef MIPS_LSU_ALIGN_CHK_EN
        StWb   = 3'd3,
        StErr  = 3'd4
`else
        StWb   = 3'd3
`endif
    } lsu_state_e;

    function automatic logic [3:0] get_mem_be(mem_sz_e sz, logic [1:0] a);
        case (sz)
            SZ_B:    return 4'b0001 << a;
            SZ_H:    return 4'b0011 << {a[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

    function automatic word_t get_st_data(mem_sz_e sz, word_t w);
        case (sz)
            SZ_B:    return {4{w[7:0]}};
            SZ_H:    return {2{w[15:0]}};
            default: return w;
        endcase
    endfunction

    // Low address bits a misaligned access would use are ignored, matching the byte enables.
    function automatic word_t get_ld_data(mem_sz_e sz, logic sgnd, logic [1:0] a, word_t d);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(d >> {a, 3'b000});
        h = 16'(d >> {a[1], 4'b0000});
        case (sz)
            SZ_B:    return {{24{sgnd & b[7]}}, b};
            SZ_H:    return {{16{sgnd & h[15]}}, h};
            default: return d;
        endcase
    endfunction

    function automatic logic is_misaligned(mem_sz_e sz, logic [1:0] a);
        return ((sz == SZ_H) && a[0]) || ((sz == SZ_W) && (a != 2'b00));
    endfunction

endpackage

// File: rtl/mips_lsu_if.sv
// Word-wide single-outstanding data-memory port between the LSU (master) and memory (slave).
interface mips_lsu_if
    import mips_lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
);
    logic              mem_req_vld;
    logic              mem_req_rdy;
    logic              mem_we;
    logic [3:0]        mem_be;
    logic [ADDR_W-1:0] mem_addr;
    word_t             mem_wdata;
    logic              mem_rsp_vld;
    word_t             mem_rsp_data;

    modport master (
        output mem_req_vld, mem_we, mem_be, mem_addr, mem_wdata,
        input  mem_req_rdy, mem_rsp_vld, mem_rsp_data
    );

    modport slave (
        input  mem_req_vld, mem_we, mem_be, mem_addr, mem_wdata,
        output mem_req_rdy, mem_rsp_vld, mem_rsp_data
    );
endinterface

// File: rtl/mips_lsu_align.sv
// Combinational byte-lane steering for stores and extract/extend for loads.
module mips_lsu_align
    import mips_lsu_pkg::*;
(
    input  mem_sz_e    sz_i,
    input  logic       sgnd_i,
    input  logic [1:0] off_i,
    input  word_t      wdata_i,
    input  word_t      rdata_i,
    output logic [3:0] be_o,
    output word_t      st_data_o,
    output word_t      ld_data_o
);
    always_comb begin
        be_o      = get_mem_be(sz_i, off_i);
        st_data_o = get_st_data(sz_i, wdata_i);
        ld_data_o = get_ld_data(sz_i, sgnd_i, off_i, rdata_i);
    end
endmodule

// File: rtl/mips_lsu.sv
// MIPS load/store unit: one op at a time from execute, word-wide memory port, load writeback pulse.
// Optional feature macro: MIPS_LSU_ALIGN_CHK_EN (misaligned H/W ops raise addr_err, no request).
module mips_lsu
    import mips_lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DST_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_vld,
    output logic              ex_rdy,
    input  mem_op_e           ex_mem_op,
    input  mem_sz_e           ex_mem_sz,
    input  logic              ex_sgnd,
    input  logic [ADDR_W-1:0] ex_addr,
    input  word_t             ex_wdata,
    input  logic [DST_W-1:0]  ex_dst,
    mips_lsu_if.master        mem_bus,
    output logic              wb_vld,
    output logic [DST_W-1:0]  wb_dst,
    output word_t             wb_data,
    output logic              addr_err,
    output logic              busy
);
    lsu_state_e        state_q, state_d;
    logic              we_q, we_d;
    mem_sz_e           sz_q, sz_d;
    logic              sgnd_q, sgnd_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    word_t             wdata_q, wdata_d;
    logic [DST_W-1:0]  dst_q, dst_d;
    logic [DST_W-1:0]  wb_dst_q, wb_dst_d;
    word_t             wb_data_q, wb_data_d;

    logic [3:0] lane_be;
    word_t      lane_st_data;
    word_t      lane_ld_data;

    // Request and response paths share the latched size/offset, so one steer serves both.
    mips_lsu_align u_align (
        .sz_i      (sz_q),
        .sgnd_i    (sgnd_q),
        .off_i     (addr_q[1:0]),
        .wdata_i   (wdata_q),
        .rdata_i   (mem_bus.mem_rsp_data),
        .be_o      (lane_be),
        .st_data_o (lane_st_data),
        .ld_data_o (lane_ld_data)
    );

    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        sz_d      = sz_q;
        sgnd_d    = sgnd_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        dst_d     = dst_q;
        wb_dst_d  = wb_dst_q;
        wb_data_d = wb_data_q;
        case (state_q)
            StIdle: begin
                if (ex_vld && (ex_mem_op != MEM_NONE)) begin
                    we_d    = (ex_mem_op == MEM_ST);
                    sz_d    = ex_mem_sz;
                    sgnd_d  = ex_sgnd;
                    addr_d  = ex_addr;
                    wdata_d = ex_wdata;
                    dst_d   = ex_dst;
`ifdef MIPS_LSU_ALIGN_CHK_EN
                    state_d = is_misaligned(ex_mem_sz, ex_addr[1:0]) ? StErr : StReq;
`else
                    state_d = StReq;
`endif
                end
            end
            StReq: begin
                if (mem_bus.mem_req_rdy) begin
                    state_d = we_q ? StIdle : StRsp;
                end
            end
            StRsp: begin
                if (mem_bus.mem_rsp_vld) begin
                    wb_data_d = lane_ld_data;
                    wb_dst_d  = dst_q;
                    state_d   = StWb;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            we_q      <= 1'b0;
            sz_q      <= SZ_B;
            sgnd_q    <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            dst_q     <= '0;
            wb_dst_q  <= '0;
            wb_data_q <= '0;
        end else begin
            state_q   <= state_d;
            we_q      <= we_d;
            sz_q      <= sz_d;
            sgnd_q    <= sgnd_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            dst_q     <= dst_d;
            wb_dst_q  <= wb_dst_d;
            wb_data_q <= wb_data_d;
        end
    end

    // Request fields are gated to zero outside StReq so idle/reset outputs read as 0.
    always_comb begin
        mem_bus.mem_req_vld = (state_q == StReq);
        mem_bus.mem_we      = (state_q == StReq) && we_q;
        mem_bus.mem_be      = (state_q == StReq) ? lane_be : 4'b0000;
        mem_bus.mem_addr    = (state_q == StReq) ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
        mem_bus.mem_wdata   = (state_q == StReq) ? lane_st_data : '0;
        ex_rdy              = (state_q == StIdle);
        busy                = (state_q != StIdle);
        wb_vld              = (state_q == StWb);
        wb_dst              = wb_dst_q;
        wb_data             = wb_data_q;
`ifdef MIPS_LSU_ALIGN_CHK_EN
        addr_err            = (state_q == StErr);
`else
        addr_err            = 1'b0;
`endif
    end
endmodule

// File: tb/tb_mips_lsu.sv
// Self-checking bench for mips_lsu: directed literal cases plus randomized ops vs a transaction model.
module tb_mips_lsu;
    import mips_lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ex_vld = 1'b0;
    logic        ex_rdy;
    mem_op_e     ex_mem_op = MEM_NONE;
    mem_sz_e     ex_mem_sz = SZ_B;
    logic        ex_sgnd = 1'b0;
    logic [31:0] ex_addr = '0;
    logic [31:0] ex_wdata = '0;
    logic [4:0]  ex_dst = '0;
    logic        wb_vld;
    logic [4:0]  wb_dst;
    logic [31:0] wb_data;
    logic        addr_err;
    logic        busy;

    mips_lsu_if #(.ADDR_W(32)) mem_bus ();

    mips_lsu #(.ADDR_W(32), .DST_W(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .ex_vld    (ex_vld),
        .ex_rdy    (ex_rdy),
        .ex_mem_op (ex_mem_op),
        .ex_mem_sz (ex_mem_sz),
        .ex_sgnd   (ex_sgnd),
        .ex_addr   (ex_addr),
        .ex_wdata  (ex_wdata),
        .ex_dst    (ex_dst),
        .mem_bus   (mem_bus.master),
        .wb_vld    (wb_vld),
        .wb_dst    (wb_dst),
        .wb_data   (wb_data),
        .addr_err  (addr_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Spec-level reference functions.
    function automatic logic [3:0] m_be(mem_sz_e sz, logic [1:0] a);
        logic [3:0] be;
        be = 4'b0000;
        if (sz == SZ_B) be[a] = 1'b1;
        else if (sz == SZ_H) begin
            be[{a[1], 1'b0}] = 1'b1;
            be[{a[1], 1'b1}] = 1'b1;
        end else be = 4'b1111;
        return be;
    endfunction

    function automatic logic [31:0] m_st(mem_sz_e sz, logic [31:0] w);
        if (sz == SZ_B) return {24'h0, w[7:0]} * 32'h0101_0101;
        if (sz == SZ_H) return {16'h0, w[15:0]} * 32'h0001_0001;
        return w;
    endfunction

    function automatic logic [31:0] m_ld(mem_sz_e sz, logic sg, logic [1:0] a, logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        b = d[8*int'(a) +: 8];
        h = d[16*int'(a[1]) +: 16];
        if (sz == SZ_B) return (sg && b[7]) ? (32'hFFFF_FF00 | b) : {24'h0, b};
        if (sz == SZ_H) return (sg && h[15]) ? (32'hFFFF_0000 | h) : {16'h0, h};
        return d;
    endfunction

    function automatic bit m_mis(mem_sz_e sz, logic [1:0] a);
`ifdef MIPS_LSU_ALIGN_CHK_EN
        return ((sz == SZ_H) && a[0]) || ((sz == SZ_W) && (a != 2'b00));
`else
        return (sz != sz) && (a != a);
`endif
    endfunction

    // Transaction model and per-cycle compare.
    bit          started = 0, chk_rst = 0;
    bit          m_rdy = 1, m_req = 0, m_wait = 0, m_wb = 0, m_err = 0;
    bit          c_st, c_sg;
    mem_sz_e     c_sz;
    logic [31:0] c_addr, c_wdata, m_wb_data;
    logic [4:0]  c_dst, m_wb_dst;
    int          n_wb_exp = 0, n_wb_dut = 0, n_hs_dut = 0;

    always @(negedge clk) begin
        if (started) begin
            if (chk_rst) begin
                chk("rst_ex_rdy", ex_rdy, 1);
                chk("rst_busy", busy, 0);
                chk("rst_req_vld", mem_bus.mem_req_vld, 0);
                chk("rst_we", mem_bus.mem_we, 0);
                chk("rst_be", mem_bus.mem_be, 0);
                chk("rst_addr", mem_bus.mem_addr, 0);
                chk("rst_wdata", mem_bus.mem_wdata, 0);
                chk("rst_wb_vld", wb_vld, 0);
                chk("rst_wb_dst", wb_dst, 0);
                chk("rst_wb_data", wb_data, 0);
                chk("rst_addr_err", addr_err, 0);
            end
            chk("ex_rdy", ex_rdy, m_rdy);
            chk("busy", busy, !m_rdy);
            chk("req_vld", mem_bus.mem_req_vld, m_req);
            if (m_req) begin
                chk("req_we", mem_bus.mem_we, c_st);
                chk("req_be", mem_bus.mem_be, m_be(c_sz, c_addr[1:0]));
                chk("req_addr", mem_bus.mem_addr, c_addr & 32'hFFFF_FFFC);
                if (c_st) chk("req_wdata", mem_bus.mem_wdata, m_st(c_sz, c_wdata));
            end
            chk("wb_vld", wb_vld, m_wb);
            if (m_wb) begin
                chk("wb_dst", wb_dst, m_wb_dst);
                chk("wb_data", wb_data, m_wb_data);
            end
            chk("addr_err", addr_err, m_err);
            if (wb_vld) n_wb_dut++;
            if (mem_bus.mem_req_vld && mem_bus.mem_req_rdy) n_hs_dut++;
        end
        chk_rst = 0;
        if (rst) begin
            started = 1;
            chk_rst = 1;
            m_rdy = 1; m_req = 0; m_wait = 0; m_wb = 0; m_err = 0;
        end else if (m_rdy) begin
            if (ex_vld && ex_mem_op != MEM_NONE) begin
                c_st = (ex_mem_op == MEM_ST); c_sz = ex_mem_sz; c_sg = ex_sgnd;
                c_addr = ex_addr; c_wdata = ex_wdata; c_dst = ex_dst;
                m_rdy = 0;
                if (m_mis(ex_mem_sz, ex_addr[1:0])) m_err = 1;
                else m_req = 1;
            end
        end else if (m_req) begin
            if (mem_bus.mem_req_rdy) begin
                m_req = 0;
                if (c_st) m_rdy = 1;
                else m_wait = 1;
            end
        end else if (m_wait) begin
            if (mem_bus.mem_rsp_vld) begin
                m_wait = 0; m_wb = 1; n_wb_exp++;
                m_wb_dst = c_dst;
                m_wb_data = m_ld(c_sz, c_sg, c_addr[1:0], mem_bus.mem_rsp_data);
            end
        end else if (m_wb) begin
            m_wb = 0; m_rdy = 1;
        end else if (m_err) begin
            m_err = 0; m_rdy = 1;
        end
    end

    // Random memory responder, active only in the random phase.
    bit auto_mem = 0;
    bit pend = 0;
    int dly = 0;
    initial begin
        mem_bus.mem_req_rdy  = 1'b0;
        mem_bus.mem_rsp_vld  = 1'b0;
        mem_bus.mem_rsp_data = '0;
        forever begin
            @(negedge clk);
            if (auto_mem && mem_bus.mem_req_vld && mem_bus.mem_req_rdy && !mem_bus.mem_we) begin
                pend = 1;
                dly = $urandom_range(0, 3);
            end
            @(posedge clk); #1;
            if (auto_mem) begin
                mem_bus.mem_req_rdy  = ($urandom_range(0, 3) != 0);
                mem_bus.mem_rsp_data = $urandom;
                if (pend && dly == 0) begin
                    mem_bus.mem_rsp_vld = 1'b1;
                    pend = 0;
                end else begin
                    if (pend) dly--;
                    mem_bus.mem_rsp_vld = !pend && ($urandom_range(0, 7) == 0);
                end
            end
        end
    end

    int n_mem_ops = 0;

    // Caller must be at posedge+1; returns at posedge+1 of the cycle after acceptance.
    task automatic issue(input mem_op_e op, input mem_sz_e sz, input bit sg,
                         input logic [31:0] a, input logic [31:0] w, input logic [4:0] d);
        bit acc = 0;
        ex_vld = 1; ex_mem_op = op; ex_mem_sz = sz; ex_sgnd = sg;
        ex_addr = a; ex_wdata = w; ex_dst = d;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge clk);
            if (ex_rdy) acc = 1;
        end
        if (!acc) chk("issue_timeout", 0, 1);
        if (acc && op != MEM_NONE && !m_mis(sz, a[1:0])) n_mem_ops++;
        @(posedge clk); #1;
        ex_vld = 0;
    endtask

    task automatic dir_load(input mem_sz_e sz, input bit sg, input logic [31:0] a,
                            input logic [4:0] d, input logic [31:0] rsp,
                            output logic [3:0] be, output logic [31:0] wd);
        mem_bus.mem_req_rdy = 1;
        issue(MEM_LD, sz, sg, a, 32'h0, d);
        @(negedge clk);
        chk("dir_req_vld", mem_bus.mem_req_vld, 1);
        be = mem_bus.mem_be;
        @(posedge clk); #1;
        mem_bus.mem_rsp_vld = 1; mem_bus.mem_rsp_data = rsp;
        @(posedge clk); #1;
        mem_bus.mem_rsp_vld = 0;
        @(negedge clk);
        chk("dir_wb_vld", wb_vld, 1);
        chk("dir_wb_dst", wb_dst, d);
        wd = wb_data;
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  be;
        logic [31:0] wd;
        bit          drained;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(posedge clk); #1;

        // SB at 0x1003
        mem_bus.mem_req_rdy = 1;
        issue(MEM_ST, SZ_B, 0, 32'h1003, 32'h0000_00A5, 5'd0);
        @(negedge clk);
        chk("sb_be", mem_bus.mem_be, 4'b1000);
        chk("sb_addr", mem_bus.mem_addr, 32'h1000);
        chk("sb_wdata", mem_bus.mem_wdata, 32'hA5A5_A5A5);
        @(posedge clk); #1;
        @(negedge clk);
        chk("sb_ex_rdy", ex_rdy, 1);
        @(posedge clk); #1;

        dir_load(SZ_B, 1, 32'h2001, 5'd7, 32'h1234_80FF, be, wd);
        chk("lb_be", be, 4'b0010);
        chk("lb_data", wd, 32'hFFFF_FF80);
        dir_load(SZ_B, 0, 32'h2001, 5'd8, 32'h1234_80FF, be, wd);
        chk("lbu_data", wd, 32'h0000_0080);
        dir_load(SZ_H, 1, 32'h2002, 5'd9, 32'h8001_0000, be, wd);
        chk("lh_be", be, 4'b1100);
        chk("lh_data", wd, 32'hFFFF_8001);

        // LW with a stalled request, a stray response in REQ and a late response
        mem_bus.mem_req_rdy = 0;
        issue(MEM_LD, SZ_W, 0, 32'h4000, 32'h0, 5'd10);
        mem_bus.mem_rsp_vld = 1; mem_bus.mem_rsp_data = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("lw_stall_ex_rdy", ex_rdy, 0);
            chk("lw_stall_addr", mem_bus.mem_addr, 32'h4000);
            @(posedge clk); #1;
            mem_bus.mem_rsp_vld = 0;
        end
        mem_bus.mem_req_rdy = 1;
        @(posedge clk); #1;
        mem_bus.mem_req_rdy = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("lw_rsp_wait_ex_rdy", ex_rdy, 0);
            @(posedge clk); #1;
        end
        mem_bus.mem_rsp_vld = 1; mem_bus.mem_rsp_data = 32'hCAFE_F00D;
        @(posedge clk); #1;
        mem_bus.mem_rsp_vld = 0;
        @(negedge clk);
        chk("lw_wb_vld", wb_vld, 1);
        chk("lw_wb_data", wb_data, 32'hCAFE_F00D);
        @(posedge clk); #1;

        // Reset while waiting for a response; the late response must be ignored
        mem_bus.mem_req_rdy = 1;
        issue(MEM_LD, SZ_W, 0, 32'h5000, 32'h0, 5'd3);
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        mem_bus.mem_rsp_vld = 1; mem_bus.mem_rsp_data = 32'h1111_1111;
        @(negedge clk);
        chk("rstrsp_ex_rdy", ex_rdy, 1);
        @(posedge clk); #1;
        mem_bus.mem_rsp_vld = 0;
        @(negedge clk);
        chk("rstrsp_wb_vld", wb_vld, 0);
        @(posedge clk); #1;
        dir_load(SZ_B, 0, 32'h2003, 5'd4, 32'h7F00_0000, be, wd);
        chk("post_rst_lbu", wd, 32'h0000_007F);

        // SW at 0x3002
        mem_bus.mem_req_rdy = 1;
        issue(MEM_ST, SZ_W, 0, 32'h3002, 32'h1234_5678, 5'd0);
        @(negedge clk);
`ifdef MIPS_LSU_ALIGN_CHK_EN
        chk("sw_mis_addr_err", addr_err, 1);
        chk("sw_mis_req_vld", mem_bus.mem_req_vld, 0);
`else
        chk("sw_mis_addr", mem_bus.mem_addr, 32'h3000);
        chk("sw_mis_be", mem_bus.mem_be, 4'b1111);
        chk("sw_mis_addr_err", addr_err, 0);
`endif
        @(posedge clk); #1;
        @(negedge clk);
        chk("sw_mis_ex_rdy", ex_rdy, 1);
        chk("sw_mis_addr_err_clr", addr_err, 0);
        @(posedge clk); #1;

        // Randomized phase
        auto_mem = 1;
        for (int k = 0; k < 400; k++) begin
            mem_op_e op;
            op = mem_op_e'(($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 2));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
            issue(op, mem_sz_e'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                  $urandom, $urandom, 5'($urandom_range(0, 31)));
        end
        drained = 0;
        for (int i = 0; i < 100 && !drained; i++) begin
            @(negedge clk);
            if (ex_rdy && !pend && !m_wait) drained = 1;
        end
        chk("drain", drained, 1);
        @(posedge clk); #1;
        auto_mem = 0;
        chk("wb_count", n_wb_dut, n_wb_exp);
        chk("req_count", n_hs_dut, n_mem_ops);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mips_lsu.md
Name: mips_lsu

Overview:
- Load/store unit that executes the memory fields the instruction decoder produces: mem_op, mem_sz and sgnd.
- Accepts one memory operation from the execute stage and drives a single-outstanding word-wide data-memory port.
- Handles byte-lane steering for stores and extract/extend for loads.
- Returns load results to writeback as a one-cycle pulse.

Parameters:
- ADDR_W, 32, byte address width.
- DST_W, 5, destination register index width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- ex_vld  in  1  execute-stage operation valid.
- ex_rdy  out  1  LSU can accept; high only in IDLE.
- ex_mem_op  in  mem_op_e  MEM_NONE/MEM_LD/MEM_ST.
- ex_mem_sz  in  mem_sz_e  SZ_B/SZ_H/SZ_W.
- ex_sgnd  in  1  sign-extend load (LB/LH); ignored for stores and SZ_W.
- ex_addr  in  ADDR_W  effective byte address.
- ex_wdata  in  32  store data (rt), right-aligned.
- ex_dst  in  DST_W  load destination register.
- mem_req_vld  out  1  memory request valid.
- mem_req_rdy  in  1  memory accepts request.
- mem_we  out  1  1=store, 0=load.
- mem_be  out  4  byte enables, little-endian lanes.
- mem_addr  out  ADDR_W  word address, bits[1:0]=0.
- mem_wdata  out  32  lane-replicated store data.
- mem_rsp_vld  in  1  load data valid; stores receive no response.
- mem_rsp_data  in  32  load word.
- wb_vld  out  1  one-cycle load writeback pulse.
- wb_dst  out  DST_W  writeback register.
- wb_data  out  32  extracted/extended load data.
- addr_err  out  1  one-cycle misalignment pulse (optional feature).
- busy  out  1  state != IDLE.

Behaviour:
- Reset: state=IDLE. All outputs 0 except ex_rdy=1: mem_req_vld, mem_we, mem_be, mem_addr, mem_wdata, wb_vld, wb_dst, wb_data, addr_err and busy are all 0.
- FSM states: IDLE, REQ, RSP, WB.
- IDLE, accept condition ex_vld&&ex_rdy:
  - MEM_NONE: dropped, stay IDLE, no outputs.
  - MEM_LD/MEM_ST: latch op, sz, sgnd, addr, wdata, dst; go to REQ.
- REQ: mem_req_vld=1; mem_we/mem_be/mem_addr/mem_wdata held stable until mem_req_rdy.
  - Store on handshake -> IDLE.
  - Load on handshake -> RSP.
- RSP: wait indefinitely for mem_rsp_vld. On it, register wb_data and wb_dst -> WB.
- WB: wb_vld=1 for exactly one cycle -> IDLE.
- mem_rsp_vld outside RSP is ignored.
- Latency, request accepted cycle T: mem_req_vld at T+1. With mem_req_rdy=1 at T+1, earliest response is T+2 and wb_vld at T+3. Store with rdy at T+1 gives ex_rdy=1 at T+2.
- Byte enables (a=addr[1:0]):
  - SZ_B: 4'b0001<<a.
  - SZ_H: 4'b0011<<{a[1],1'b0}.
  - SZ_W: 4'b1111.
- Store data: SZ_B {4{wdata[7:0]}}; SZ_H {2{wdata[15:0]}}; SZ_W wdata.
- Load extract: shifted = mem_rsp_data >> (8*a), using the same lane rules as the byte enables.
  - B: bits[7:0], sign-extended if sgnd else zero-extended.
  - H: bits[15:0], same extension rule.
  - W: full word.
- Reset asserted in any state returns the FSM to IDLE next edge and clears the outputs. A response to an abandoned load then arrives in IDLE and is ignored.
- Back-to-back: a new op can be accepted the cycle ex_rdy returns high. There is no bypass from WB to IDLE in the same cycle.

Optional Feature:
- MIPS_LSU_ALIGN_CHK_EN defined:
  - Misalignment is SZ_H with addr[0]=1, or SZ_W with addr[1:0]!=0.
  - On accepting a misaligned op, go to an ERR state, not REQ. No memory request is issued.
  - addr_err=1 for one cycle (T+1), wb_vld stays 0, then IDLE.
- Undefined:
  - No ERR state; addr_err is tied 0.
  - Misaligned low bits are ignored: H uses {a[1],0}, W uses 0.

Decomposition:
- mips_pkg gains:
  - lsu_state_e.
  - get_mem_be(mem_sz_e, logic[1:0]).
  - get_st_data(mem_sz_e, word_t).
  - get_ld_data(mem_sz_e, logic sgnd, logic[1:0], word_t).
  - is_misaligned(mem_sz_e, logic[1:0]).
- mem_op_e and mem_sz_e are reused from the shared types.
- One sub-module is natural: mips_lsu_align, the combinational lane steer and load extend, instantiated for both the request and the response paths.

Test Plan:
- SB, addr=0x1003, wdata=0x000000A5 -> mem_be=4'b1000, mem_addr=0x1000, mem_wdata=0xA5A5A5A5, no wb_vld, ex_rdy=1 one cycle after handshake.
- LB, sgnd=1, addr=0x2001, rsp=0x1234_80FF -> wb_data=0xFFFFFF80, wb_dst=ex_dst, wb_vld one cycle. Same stimulus as LBU (sgnd=0) -> wb_data=0x00000080.
- LH, sgnd=1, addr=0x2002, rsp=0x8001_0000 -> mem_be=4'b1100, wb_data=0xFFFF8001.
- LW with mem_req_rdy low 3 cycles and response 4 cycles later -> request fields stable throughout, ex_rdy=0 until WB passes, a stray mem_rsp_vld in REQ ignored.
- rst pulsed during RSP, then mem_rsp_vld=1 -> no wb_vld, all outputs at reset values, next op accepted normally.
- With MIPS_LSU_ALIGN_CHK_EN, SW at addr=0x3002 -> addr_err one-cycle pulse, mem_req_vld never asserted. Without the macro -> mem_addr=0x3000, mem_be=4'b1111, addr_err=0.
